traffic_ctrl: RTL and testbench
===============================

Name: traffic_ctrl

Overview:
Two-way intersection controller (north-south / east-west). It sequences the light phases from a 1 Hz tick derived from the system clock. It produces two 2-digit BCD countdowns packed into a 16-bit word, which feeds the 4-digit 7-segment scanner directly downstream (q_a input: digits 3..0 left to right). It also provides an emergency all-red override.

Parameters:
TICK_DIV, 50000000, system clocks per 1 s tick (>= 2)
GREEN_S, 25, green phase duration in seconds (1..94)
YELLOW_S, 5, yellow phase duration in seconds (1..5); GREEN_S+YELLOW_S <= 99

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
emerg  input  1  emergency override, level, active-high, synchronous to clk
q_a  output  16  BCD countdowns: [15:12] NS tens, [11:8] NS units, [7:4] EW tens, [3:0] EW units
ns_light  output  3  NS lamps {red, yellow, green}, one-hot, active-high
ew_light  output  3  EW lamps {red, yellow, green}, one-hot, active-high
phase  output  3  current FSM state encoding, for debug/verification

Behaviour:
- One clock domain. Reset is synchronous active-low: sampled on the clk rising edge only.
- Prescaler pre: 0..TICK_DIV-1, wraps to 0. tick = 1 for exactly the one cycle where pre == TICK_DIV-1.
- Phase timer T: binary, 7 bits. Holds the remaining seconds of the current phase, range 1..duration. It never holds 0.
- FSM states, with phase codes:
  - NS_G (0): duration GREEN_S
  - NS_Y (1): duration YELLOW_S
  - EW_G (2): duration GREEN_S
  - EW_Y (3): duration YELLOW_S
  - EMERG (4)
- On tick with T == 1: advance NS_G->NS_Y->EW_G->EW_Y->NS_G and load T with the new state's duration. On tick with T > 1: T <= T-1. With no tick: hold.
- Displayed values, computed from state and T:
  - NS_G: NS = T, EW = T+YELLOW_S
  - NS_Y: NS = T, EW = T
  - EW_G: NS = T+YELLOW_S, EW = T
  - EW_Y: NS = T, EW = T
  - EMERG: q_a = 16'hEEEE
- Each displayed value is converted to 2-digit BCD (tens = v/10, units = v%10; always <= 99). Every output nibble is 0..9 except in EMERG.
- Lamps:
  - NS_G: ns 001, ew 100
  - NS_Y: ns 010, ew 100
  - EW_G: ns 100, ew 001
  - EW_Y: ns 100, ew 010
  - EMERG: ns 100, ew 100
- Latency: q_a, ns_light and ew_light are registered. Each reflects state/T exactly one clock after state/T change. phase is the state register itself (zero latency).
- Emergency:
  - emerg == 1 on any edge (not in reset): state <= EMERG, pre <= 0, T <= GREEN_S. This has priority over tick.
  - While in EMERG, state, pre and T are held.
  - On the first edge with emerg == 0 while in EMERG: state <= NS_G, T <= GREEN_S, pre <= 0 (a full tick period before the first decrement).
- Reset (reset_n == 0 at edge), highest priority over emerg and tick:
  - state NS_G, T = GREEN_S, pre = 0
  - q_a = BCD(GREEN_S), BCD(GREEN_S+YELLOW_S); 16'h2530 with defaults
  - ns_light 001, ew_light 100, phase 0
  - Reset mid-phase discards the countdown immediately.
- Wrap: EW_Y with T == 1 on tick returns to NS_G with a full GREEN_S; the sequence repeats indefinitely.
- Never drive a lamp pattern with both directions non-red, and never a non-one-hot lamp pattern. Verified by assertion every cycle.

Test Plan:
All scenarios use TICK_DIV=4, GREEN_S=3, YELLOW_S=2.
1. Reset held 3 cycles then released -> q_a 16'h0305, ns 001, ew 100, phase 0. The first tick arrives on the 4th edge after release, and q_a becomes 16'h0204 one edge later.
2. Run 10 ticks -> q_a sequence 0305, 0204, 0103, 0202, 0101, 0503, 0402, 0301, 0202, 0101, then back to 0305 with phase 0. Lamps match each state; phase sequence 0,0,0,1,1,2,2,2,3,3.
3. Assert emerg for 7 cycles mid NS_Y -> phase 4 on the next edge; q_a 16'hEEEE and both lamps 100 one edge later. On release: phase 0, q_a 16'h0305, next decrement exactly 4 cycles after release.
4. Pull reset_n low for 1 cycle during EW_G with T=2 -> next edge phase 0, T=3, and q_a 16'h0305 / lamps reset values regardless of prior state.
5. Assert emerg and reset_n low on the same edge -> reset wins: phase 0. If emerg is still high on the next edge, phase 4.
6. Override GREEN_S=25, YELLOW_S=5, TICK_DIV=2, run a full cycle -> q_a after reset 16'h2530. BCD carry boundary: 16'h1015 followed by 16'h0914. All nibbles <= 9 throughout; lamp assertion never fires.

Source files
------------

// File: rtl/traffic_ctrl.sv
// Two-way intersection controller: 1 Hz phase sequencer, packed BCD countdowns
// for a 4-digit 7-segment scanner, and an all-red emergency override.
module traffic_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        emerg,
    output logic [15:0] q_a,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic [2:0]  phase
);
    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        EW_G  = 3'd2,
        EW_Y  = 3'd3,
        EMERG = 3'd4
    } state_t;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v % 7'd10);
        return {tens, units};
    endfunction

    localparam int                PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]        GREEN_T  = 7'(GREEN_S);
    localparam logic [6:0]        YELLOW_T = 7'(YELLOW_S);
    localparam logic [15:0]       RESET_QA = {to_bcd(GREEN_T), to_bcd(GREEN_T + YELLOW_T)};

    state_t           state_reg;
    logic [6:0]       t_reg;
    logic [PRE_W-1:0] pre_reg;
    logic             tick;

    logic [15:0]      q_a_reg;
    logic [2:0]       ns_light_reg;
    logic [2:0]       ew_light_reg;

    // Index 0 is the NS display value, index 1 the EW display value.
    logic [6:0]       disp_next [2];
    logic [7:0]       bcd_next  [2];
    logic [15:0]      q_a_next;
    logic [2:0]       ns_light_next;
    logic [2:0]       ew_light_next;

    state_t           adv_state;
    logic [6:0]       adv_t;

    assign tick = (pre_reg == PRE_LAST);

    always_comb begin
        disp_next[0]  = t_reg;
        disp_next[1]  = t_reg;
        ns_light_next = 3'b100;
        ew_light_next = 3'b100;
        case (state_reg)
            NS_G: begin
                disp_next[1]  = t_reg + YELLOW_T;
                ns_light_next = 3'b001;
            end
            NS_Y: ns_light_next = 3'b010;
            EW_G: begin
                disp_next[0]  = t_reg + YELLOW_T;
                ew_light_next = 3'b001;
            end
            EW_Y: ew_light_next = 3'b010;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bcd
            assign bcd_next[gi] = to_bcd(disp_next[gi]);
        end
    endgenerate

    assign q_a_next = (state_reg == EMERG) ? 16'hEEEE : {bcd_next[0], bcd_next[1]};

    // Successor phase and its full duration, used when the timer expires.
    always_comb begin
        adv_state = NS_G;
        adv_t     = GREEN_T;
        case (state_reg)
            NS_G: begin
                adv_state = NS_Y;
                adv_t     = YELLOW_T;
            end
            NS_Y: begin
                adv_state = EW_G;
                adv_t     = GREEN_T;
            end
            EW_G: begin
                adv_state = EW_Y;
                adv_t     = YELLOW_T;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= NS_G;
            t_reg        <= GREEN_T;
            pre_reg      <= '0;
            q_a_reg      <= RESET_QA;
            ns_light_reg <= 3'b001;
            ew_light_reg <= 3'b100;
        end else begin
            q_a_reg      <= q_a_next;
            ns_light_reg <= ns_light_next;
            ew_light_reg <= ew_light_next;
            if (emerg) begin
                state_reg <= EMERG;
                pre_reg   <= '0;
                t_reg     <= GREEN_T;
            end else if (state_reg == EMERG) begin
                // Restart with a full tick period before the first decrement.
                state_reg <= NS_G;
                pre_reg   <= '0;
                t_reg     <= GREEN_T;
            end else begin
                pre_reg <= tick ? '0 : pre_reg + PRE_W'(1);
                if (tick) begin
                    if (t_reg == 7'd1) begin
                        state_reg <= adv_state;
                        t_reg     <= adv_t;
                    end else begin
                        t_reg <= t_reg - 7'd1;
                    end
                end
            end
        end
    end

    assign q_a      = q_a_reg;
    assign ns_light = ns_light_reg;
    assign ew_light = ew_light_reg;
    assign phase    = state_reg;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: vector table, directed corner sequences, and random
// reset/emergency stimulus checked against an elapsed-seconds reference model.
module tb_traffic_ctrl;
    localparam int TD = 4;
    localparam int G  = 3;
    localparam int Y  = 2;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        emerg    = 1'b0;
    logic        reset_n2 = 1'b0;
    logic        emerg2   = 1'b0;
    logic [15:0] q_a;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic [2:0]  phase;
    logic [15:0] q_a2;
    logic [2:0]  ns2;
    logic [2:0]  ew2;
    logic [2:0]  phase2;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: seconds elapsed since the last restart of the cycle.
    int          m_k   = 0;
    int          m_cyc = 0;
    bit          m_em  = 1'b0;
    logic [31:0] exp_q;
    logic [31:0] exp_ns;
    logic [31:0] exp_ew;
    logic [31:0] exp_ph;

    typedef struct {
        int          edges;
        logic        emerg;
        logic [15:0] q;
        logic [2:0]  ph;
        logic [2:0]  ns;
        logic [2:0]  ew;
    } vec_t;
    vec_t tbl [11];

    logic [15:0] prev_q2;
    logic [2:0]  prev_ph2;
    int          saw_carry;
    bit          wrap_pending;

    always #5 clk = ~clk;

    traffic_ctrl #(.TICK_DIV(TD), .GREEN_S(G), .YELLOW_S(Y)) dut (
        .clk(clk), .reset_n(reset_n), .emerg(emerg),
        .q_a(q_a), .ns_light(ns_light), .ew_light(ew_light), .phase(phase)
    );

    traffic_ctrl #(.TICK_DIV(2), .GREEN_S(25), .YELLOW_S(5)) dut2 (
        .clk(clk), .reset_n(reset_n2), .emerg(emerg2),
        .q_a(q_a2), .ns_light(ns2), .ew_light(ew2), .phase(phase2)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic void view(input int k, input bit em, output int ph, output int t);
        int p;
        p = k % (2 * (G + Y));
        if (em) begin
            ph = 4; t = G;
        end else if (p < G) begin
            ph = 0; t = G - p;
        end else if (p < G + Y) begin
            ph = 1; t = G + Y - p;
        end else if (p < 2 * G + Y) begin
            ph = 2; t = 2 * G + Y - p;
        end else begin
            ph = 3; t = 2 * (G + Y) - p;
        end
    endfunction

    function automatic void outs(input int ph, input int t,
                                 output logic [31:0] q, output logic [31:0] ns,
                                 output logic [31:0] ew);
        case (ph)
            0: begin q = {16'h0, bcd(t), bcd(t + Y)}; ns = 32'd1; ew = 32'd4; end
            1: begin q = {16'h0, bcd(t), bcd(t)};     ns = 32'd2; ew = 32'd4; end
            2: begin q = {16'h0, bcd(t + Y), bcd(t)}; ns = 32'd4; ew = 32'd1; end
            3: begin q = {16'h0, bcd(t), bcd(t)};     ns = 32'd4; ew = 32'd2; end
            default: begin q = 32'hEEEE; ns = 32'd4; ew = 32'd4; end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic invariants(input string who, input logic [2:0] ns, input logic [2:0] ew,
                              input logic [15:0] q);
        logic ok;
        ok = (ns inside {3'b001, 3'b010, 3'b100}) && (ew inside {3'b001, 3'b010, 3'b100})
             && (ns == 3'b100 || ew == 3'b100);
        check({who, "_lamp_safe"}, {31'b0, ok}, 32'd1);
        if (!(ns == 3'b100 && ew == 3'b100)) begin
            ok = 1'b1;
            for (int i = 0; i < 4; i++)
                if (q[i*4 +: 4] > 4'd9) ok = 1'b0;
            check({who, "_nibble_bcd"}, {31'b0, ok}, 32'd1);
        end
    endtask

    task automatic step();
        int ph;
        int t;
        if (!reset_n) begin
            outs(0, G, exp_q, exp_ns, exp_ew);
            m_k = 0; m_cyc = 0; m_em = 1'b0;
        end else begin
            view(m_k, m_em, ph, t);
            outs(ph, t, exp_q, exp_ns, exp_ew);
            if (emerg) begin
                m_em = 1'b1;
            end else if (m_em) begin
                m_em = 1'b0; m_k = 0; m_cyc = 0;
            end else begin
                m_cyc++;
                if (m_cyc == TD) begin
                    m_cyc = 0;
                    m_k++;
                end
            end
        end
        view(m_k, m_em, ph, t);
        exp_ph = 32'(ph);
        @(posedge clk);
        #1;
        check("model_phase", 32'(phase), exp_ph);
        check("model_q_a", 32'(q_a), exp_q);
        check("model_ns", 32'(ns_light), exp_ns);
        check("model_ew", 32'(ew_light), exp_ew);
        $display("cyc rst=%0b em=%0b phase=%0d q_a=%h ns=%b ew=%b | dut2 phase=%0d q_a=%h",
                 reset_n, emerg, phase, q_a, ns_light, ew_light, phase2, q_a2);
        invariants("dut1", ns_light, ew_light, q_a);
        invariants("dut2", ns2, ew2, q_a2);
    endtask

    task automatic wait_phase(input logic [2:0] target, input string name);
        int n;
        n = 0;
        while (phase !== target && n < 200) begin
            step();
            n++;
        end
        if (phase !== target) check(name, 32'(phase), 32'(target));
    endtask

    initial begin
        tbl[0]  = '{1, 1'b0, 16'h0305, 3'd0, 3'b001, 3'b100};
        tbl[1]  = '{4, 1'b0, 16'h0204, 3'd0, 3'b001, 3'b100};
        tbl[2]  = '{4, 1'b0, 16'h0103, 3'd0, 3'b001, 3'b100};
        tbl[3]  = '{4, 1'b0, 16'h0202, 3'd1, 3'b010, 3'b100};
        tbl[4]  = '{4, 1'b0, 16'h0101, 3'd1, 3'b010, 3'b100};
        tbl[5]  = '{4, 1'b0, 16'h0503, 3'd2, 3'b100, 3'b001};
        tbl[6]  = '{4, 1'b0, 16'h0402, 3'd2, 3'b100, 3'b001};
        tbl[7]  = '{4, 1'b0, 16'h0301, 3'd2, 3'b100, 3'b001};
        tbl[8]  = '{4, 1'b0, 16'h0202, 3'd3, 3'b100, 3'b010};
        tbl[9]  = '{4, 1'b0, 16'h0101, 3'd3, 3'b100, 3'b010};
        tbl[10] = '{4, 1'b0, 16'h0305, 3'd0, 3'b001, 3'b100};

        // Reset held, then first tick timing.
        reset_n = 1'b0;
        repeat (3) begin
            step();
            check("rst_q_a", 32'(q_a), 32'h0305);
            check("rst_ns", 32'(ns_light), 32'b001);
            check("rst_ew", 32'(ew_light), 32'b100);
            check("rst_phase", 32'(phase), 32'd0);
        end
        reset_n = 1'b1;
        repeat (4) step();
        check("first_tick_hold", 32'(q_a), 32'h0305);
        step();
        check("first_tick_q_a", 32'(q_a), 32'h0204);

        // Full phase cycle from the vector table.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            emerg = tbl[i].emerg;
            repeat (tbl[i].edges) step();
            check($sformatf("tbl%0d_q_a", i), 32'(q_a), 32'(tbl[i].q));
            check($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
            check($sformatf("tbl%0d_ns", i), 32'(ns_light), 32'(tbl[i].ns));
            check($sformatf("tbl%0d_ew", i), 32'(ew_light), 32'(tbl[i].ew));
        end

        // Emergency during NS yellow.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wait_phase(3'd1, "wait_ns_y");
        step();
        emerg = 1'b1;
        step();
        check("emerg_phase", 32'(phase), 32'd4);
        check("emerg_q_a_lag", 32'(q_a), 32'h0202);
        step();
        check("emerg_q_a", 32'(q_a), 32'hEEEE);
        check("emerg_ns", 32'(ns_light), 32'b100);
        check("emerg_ew", 32'(ew_light), 32'b100);
        repeat (5) begin
            step();
            check("emerg_hold_phase", 32'(phase), 32'd4);
        end
        emerg = 1'b0;
        step();
        check("emerg_release_phase", 32'(phase), 32'd0);
        step();
        check("emerg_release_q_a", 32'(q_a), 32'h0305);
        repeat (3) step();
        check("emerg_release_hold", 32'(q_a), 32'h0305);
        step();
        check("emerg_release_tick", 32'(q_a), 32'h0204);

        // Reset mid EW green with T=2.
        wait_phase(3'd2, "wait_ew_g");
        repeat (5) step();
        check("ew_g_t2_q_a", 32'(q_a), 32'h0402);
        reset_n = 1'b0;
        step();
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_q_a", 32'(q_a), 32'h0305);
        check("midrst_ns", 32'(ns_light), 32'b001);
        check("midrst_ew", 32'(ew_light), 32'b100);
        reset_n = 1'b1;
        step();
        check("midrst_after_q_a", 32'(q_a), 32'h0305);

        // Reset and emergency on the same edge.
        emerg   = 1'b1;
        reset_n = 1'b0;
        step();
        check("rst_beats_emerg", 32'(phase), 32'd0);
        reset_n = 1'b1;
        step();
        check("emerg_after_rst", 32'(phase), 32'd4);
        emerg = 1'b0;
        step();
        check("emerg_after_rst_release", 32'(phase), 32'd0);

        // Default timing instance: reset value, BCD carry and wrap.
        check("dut2_rst_q_a", 32'(q_a2), 32'h2530);
        check("dut2_rst_phase", 32'(phase2), 32'd0);
        check("dut2_rst_ns", 32'(ns2), 32'b001);
        check("dut2_rst_ew", 32'(ew2), 32'b100);
        reset_n2     = 1'b1;
        prev_q2      = q_a2;
        prev_ph2     = phase2;
        saw_carry    = 0;
        wrap_pending = 1'b0;
        for (int i = 0; i < 240; i++) begin
            step();
            if (wrap_pending) begin
                check("dut2_wrap_q_a", 32'(q_a2), 32'h2530);
                wrap_pending = 1'b0;
            end
            if (prev_ph2 == 3'd3 && phase2 == 3'd0) wrap_pending = 1'b1;
            if (q_a2 != prev_q2 && prev_q2 == 16'h1015) begin
                check("dut2_bcd_carry", 32'(q_a2), 32'h0914);
                saw_carry++;
            end
            prev_q2  = q_a2;
            prev_ph2 = phase2;
        end
        check("dut2_carry_count", 32'(saw_carry), 32'd2);

        // Random reset/emergency stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) emerg = ~emerg;
            reset_n = ($urandom_range(0, 249) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
